bmp_gray_ctrl: RTL and testbench

- Controller (initiator) for the BMP single-port RAM. Walks every pixel of a 24-bit BMP image stored in the RAM and converts it to grey in place.
- For each pixel it reads the B, G and R bytes, computes a weighted luma value, and writes that value back into all three bytes.
- Sits between the top-level sequencer (start/busy/done) and the RAM's ren/wen/addr/in/out port.
- Skips the BMP header and the per-row 4-byte alignment padding.

---
 rtl/bmp_gray_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_bmp_gray_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_gray_ctrl.sv
// In-place greyscale conversion controller for a 24-bit BMP held in a
// byte-wide single-port RAM: reads B,G,R of each pixel, writes luma back.
module bmp_gray_ctrl #(
    parameter int ADDR_WIDTH  = 20,
    parameter int BYTE_WIDTH  = 8,
    parameter int HEADER_SIZE = 54,
    parameter int IMG_WIDTH   = 512,
    parameter int IMG_HEIGHT  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [BYTE_WIDTH-1:0] RAM_in,
    input  logic [BYTE_WIDTH-1:0] RAM_out
);

    // Rows are padded so that each one starts on a 4-byte boundary.
    localparam int PAD   = (4 - ((3 * IMG_WIDTH) % 4)) % 4;
    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    localparam logic [ADDR_WIDTH-1:0] FIRST_PIXEL = ADDR_WIDTH'(HEADER_SIZE);
    localparam logic [ADDR_WIDTH-1:0] PIXEL_STEP  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP    = ADDR_WIDTH'(3 + PAD);
    localparam logic [ADDR_WIDTH-1:0] OFS_G       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] OFS_R       = ADDR_WIDTH'(2);

    typedef enum logic [3:0] {
        IDLE,
        RD_B,
        RD_G,
        RD_R,
        RD_HOLD,
        CALC,
        WR_B,
        WR_G,
        WR_R,
        FIN
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic [ADDR_WIDTH-1:0]   base;
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic                    last_pixel;

    logic [BYTE_WIDTH-1:0]   b_reg;
    logic [BYTE_WIDTH-1:0]   g_reg;
    logic [BYTE_WIDTH-1:0]   r_reg;
    logic [BYTE_WIDTH-1:0]   gray_reg;
    logic [BYTE_WIDTH-1:0]   gray_next;
    logic [16:0]             luma_sum;

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pixel walker: base address plus column/row position in the image.
    always_ff @(posedge clk) begin
        if (rst) begin
            base <= '0;
            col  <= '0;
            row  <= '0;
        end else if (state == IDLE && start) begin
            base <= FIRST_PIXEL;
            col  <= '0;
            row  <= '0;
        end else if (state == WR_R) begin
            if (col == LAST_COL) begin
                col  <= '0;
                row  <= row + ROW_W'(1);
                base <= base + ROW_STEP;
            end else begin
                col  <= col + COL_W'(1);
                base <= base + PIXEL_STEP;
            end
        end
    end

    // Capture read data one cycle after each address, then latch the luma.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg    <= '0;
            g_reg    <= '0;
            r_reg    <= '0;
            gray_reg <= '0;
        end else begin
            if (state == RD_G) begin
                b_reg <= RAM_out;
            end
            if (state == RD_R) begin
                g_reg <= RAM_out;
            end
            if (state == RD_HOLD) begin
                r_reg <= RAM_out;
            end
            if (state == CALC) begin
                gray_reg <= gray_next;
            end
        end
    end

    // Weighted luma with rounding; weights sum to 256 so the result fits a byte.
    always_comb begin
        luma_sum = 17'd29  * 17'(b_reg)
                 + 17'd150 * 17'(g_reg)
                 + 17'd77  * 17'(r_reg)
                 + 17'd128;
        gray_next = BYTE_WIDTH'(luma_sum >> 8);
    end

    // Final pixel of the image is the last column of the last row.
    always_comb begin
        last_pixel = (col == LAST_COL) && (row == LAST_ROW);
    end

    // Next-state and RAM strobe decode.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        RAM_ren    = 1'b0;
        RAM_wen    = 1'b0;
        RAM_addr   = '0;
        RAM_in     = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = RD_B;
                end
            end
            RD_B: begin
                busy       = 1'b1;
                RAM_ren    = 1'b1;
                RAM_addr   = base;
                next_state = RD_G;
            end
            RD_G: begin
                busy       = 1'b1;
                RAM_ren    = 1'b1;
                RAM_addr   = base + OFS_G;
                next_state = RD_R;
            end
            RD_R: begin
                busy       = 1'b1;
                RAM_ren    = 1'b1;
                RAM_addr   = base + OFS_R;
                next_state = RD_HOLD;
            end
            RD_HOLD: begin
                busy       = 1'b1;
                RAM_ren    = 1'b1;
                RAM_addr   = base + OFS_R;
                next_state = CALC;
            end
            CALC: begin
                busy       = 1'b1;
                next_state = WR_B;
            end
            WR_B: begin
                busy       = 1'b1;
                RAM_wen    = 1'b1;
                RAM_addr   = base;
                RAM_in     = gray_reg;
                next_state = WR_G;
            end
            WR_G: begin
                busy       = 1'b1;
                RAM_wen    = 1'b1;
                RAM_addr   = base + OFS_G;
                RAM_in     = gray_reg;
                next_state = WR_R;
            end
            WR_R: begin
                busy       = 1'b1;
                RAM_wen    = 1'b1;
                RAM_addr   = base + OFS_R;
                RAM_in     = gray_reg;
                next_state = last_pixel ? FIN : RD_B;
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bmp_gray_ctrl.sv
// Scoreboard bench for bmp_gray_ctrl: three image geometries, RAM model,
// reference luma model, write/done queues checked by a separate monitor.
module tb_bmp_gray_ctrl;

    localparam int NI = 3;
    localparam int AW = 20;
    localparam int HDR = 54;
    localparam int WD [NI] = '{1, 2, 4};
    localparam int HT [NI] = '{1, 2, 3};

    typedef struct {
        int a;
        int d;
    } wr_t;

    typedef struct {
        int st;
        int dn;
    } run_t;

    logic clk = 1'b0;
    logic rst;
    logic start [NI];
    logic fill [NI];
    logic busy [NI];
    logic done [NI];
    logic ren [NI];
    logic wen [NI];
    logic [AW-1:0] addr [NI];
    logic [7:0] din [NI];
    logic [7:0] q [NI];
    logic [7:0] mem [NI][256];
    logic [7:0] shadow [NI][256];
    bit to_err [NI];

    wr_t wq [NI][$];
    run_t dq [NI][$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int chk_req = 0;
    int chk_ack = 0;
    int chk_g = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bmp_gray_ctrl #(
            .ADDR_WIDTH (AW),
            .BYTE_WIDTH (8),
            .HEADER_SIZE(HDR),
            .IMG_WIDTH  (g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .IMG_HEIGHT (g == 0 ? 1 : (g == 1 ? 2 : 3))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .RAM_ren (ren[g]),
            .RAM_wen (wen[g]),
            .RAM_addr(addr[g]),
            .RAM_in  (din[g]),
            .RAM_out (q[g])
        );
    end

    // Synchronous single-port RAM per instance; fill loads the shadow image.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (fill[g]) begin
                for (int a = 0; a < 256; a++) mem[g][a] <= shadow[g][a];
            end else if (wen[g]) begin
                mem[g][addr[g][7:0]] <= din[g];
            end else if (ren[g]) begin
                q[g] <= mem[g][addr[g][7:0]];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int stride(int g);
        return ((3 * WD[g] + 3) / 4) * 4;
    endfunction

    function automatic bit is_px(int g, int a);
        int off;
        if (a < HDR) return 1'b0;
        off = a - HDR;
        return (off / stride(g) < HT[g]) && (off % stride(g) < 3 * WD[g]);
    endfunction

    task automatic chk(bit ok, string nm, longint act, longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: all comparisons happen here, away from the clock edge.
    initial begin
        bit last_rst = 1'b0;
        wr_t e;
        run_t r;
        bit bexp;
        int nbad;
        int first_bad;
        int g;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (last_rst) begin
                    wq[i].delete();
                    dq[i].delete();
                    chk({busy[i], done[i], ren[i], wen[i]} == 4'b0, $sformatf("rst_strobes%0d", i), {busy[i], done[i], ren[i], wen[i]}, 0);
                    chk(addr[i] == '0 && din[i] == '0, $sformatf("rst_addr_data%0d", i), addr[i] + din[i], 0);
                end
                chk(!(ren[i] && wen[i]), $sformatf("ren_wen_excl%0d", i), 2, 1);
                bexp = 1'b0;
                if (dq[i].size() != 0) begin
                    r = dq[i][0];
                    bexp = (cyc > r.st) && (cyc < r.dn);
                end
                chk(busy[i] == bexp, $sformatf("busy%0d", i), busy[i], bexp);
                if (ren[i]) begin
                    chk(is_px(i, int'(addr[i])), $sformatf("rd_addr%0d_at_%0d", i, addr[i]), 0, 1);
                end
                if (wen[i]) begin
                    if (wq[i].size() == 0) begin
                        chk(1'b0, $sformatf("wr_extra%0d", i), addr[i], -1);
                    end else begin
                        e = wq[i].pop_front();
                        chk(int'(addr[i]) == e.a, $sformatf("wr_addr%0d", i), addr[i], e.a);
                        chk(int'(din[i]) == e.d, $sformatf("wr_data%0d_at_%0d", i, e.a), din[i], e.d);
                    end
                end
                if (done[i]) begin
                    if (dq[i].size() == 0) begin
                        chk(1'b0, $sformatf("done_extra%0d", i), cyc, -1);
                    end else begin
                        r = dq[i].pop_front();
                        chk(cyc == r.dn, $sformatf("done_cycle%0d", i), cyc, r.dn);
                    end
                end
            end
            if (chk_ack != chk_req) begin
                g = chk_g;
                chk(wq[g].size() == 0, $sformatf("wr_missing%0d", g), wq[g].size(), 0);
                chk(dq[g].size() == 0, $sformatf("done_missing%0d", g), dq[g].size(), 0);
                chk(!to_err[g], $sformatf("timeout%0d", g), 1, 0);
                nbad = 0;
                first_bad = -1;
                for (int a = 0; a < 256; a++) begin
                    if (mem[g][a] != shadow[g][a]) begin
                        nbad++;
                        if (first_bad < 0) first_bad = a;
                    end
                end
                chk(nbad == 0, $sformatf("mem_image%0d_first_bad_%0d", g, first_bad), nbad, 0);
                chk_ack++;
            end
            last_rst = rst;
        end
    end

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(int g);
        @(posedge clk);
        #1;
        fill[g] = 1'b1;
        @(posedge clk);
        #1;
        fill[g] = 1'b0;
    endtask

    // Reference: every pixel becomes round((29B+150G+77R)/256) in all bytes.
    task automatic model_run(int g, int limit, bit push);
        int n = 0;
        int a;
        int gy;
        for (int y = 0; y < HT[g]; y++) begin
            for (int x = 0; x < WD[g]; x++) begin
                a = HDR + y * stride(g) + 3 * x;
                gy = (29 * shadow[g][a] + 150 * shadow[g][a + 1] + 77 * shadow[g][a + 2] + 128) / 256;
                for (int k = 0; k < 3; k++) begin
                    if (n < limit) begin
                        shadow[g][a + k] = 8'(gy);
                        if (push) wq[g].push_back('{a + k, gy});
                    end
                    n++;
                end
            end
        end
    endtask

    task automatic start_run(int g, int c, output int k);
        int npx = WD[g] * HT[g];
        goto(c);
        k = cyc;
        model_run(g, 3 * npx, 1'b1);
        dq[g].push_back('{k, k + 8 * npx + 1});
        start[g] = 1'b1;
        @(posedge clk);
        #1;
        start[g] = 1'b0;
    endtask

    task automatic pulse(int g, int c);
        goto(c);
        start[g] = 1'b1;
        @(posedge clk);
        #1;
        start[g] = 1'b0;
    endtask

    task automatic finish_run(int g);
        int n = 0;
        while (dq[g].size() != 0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 4000) to_err[g] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk_g = g;
        chk_req++;
        n = 0;
        while (chk_ack != chk_req && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (chk_ack != chk_req) begin
            $display("FAIL monitor_handshake: got %0d, want %0d", chk_ack, chk_req);
            $fatal(1, "monitor stalled");
        end
    endtask

    task automatic fill_img(int g);
        for (int a = 0; a < 256; a++) shadow[g][a] = 8'hAA;
        for (int y = 0; y < HT[g]; y++) begin
            for (int x = 0; x < 3 * WD[g]; x++) begin
                shadow[g][HDR + y * stride(g) + x] = 8'($urandom);
            end
        end
        load(g);
    endtask

    task automatic set_px0(int b, int gg, int r);
        for (int a = 0; a < 256; a++) shadow[0][a] = 8'hAA;
        shadow[0][HDR] = 8'(b);
        shadow[0][HDR + 1] = 8'(gg);
        shadow[0][HDR + 2] = 8'(r);
        load(0);
    endtask

    // Stimulus.
    initial begin
        int k;
        int k2;
        logic [7:0] bk [256];
        int tb_b [6] = '{255, 0, 0, 255, 0, 37};
        int tb_g [6] = '{0, 0, 255, 255, 0, 201};
        int tb_r [6] = '{0, 255, 0, 255, 0, 90};
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0;
            fill[g] = 1'b0;
            to_err[g] = 1'b0;
            for (int a = 0; a < 256; a++) shadow[g][a] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1x1 image: latency, ignored starts while busy and in FIN, restart.
        set_px0(100, 100, 100);
        start_run(0, cyc, k);
        pulse(0, k + 3);
        pulse(0, k + 9);
        start_run(0, k + 10, k2);
        finish_run(0);

        for (int i = 0; i < 6; i++) begin
            set_px0(tb_b[i], tb_g[i], tb_r[i]);
            start_run(0, cyc, k);
            finish_run(0);
        end
        for (int i = 0; i < 4; i++) begin
            fill_img(0);
            start_run(0, cyc, k);
            finish_run(0);
        end

        // 2x2 image with two padding bytes per row.
        for (int i = 0; i < 4; i++) begin
            fill_img(1);
            start_run(1, cyc, k);
            finish_run(1);
        end

        // 4x3 image: abort in WR_G of the third pixel, then reconvert.
        fill_img(2);
        for (int a = 0; a < 256; a++) bk[a] = shadow[2][a];
        start_run(2, cyc, k);
        goto(k + 23);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < 256; a++) shadow[2][a] = bk[a];
        model_run(2, 8, 1'b0);
        goto(k + 26);
        finish_run(2);
        start_run(2, cyc, k);
        finish_run(2);
        for (int i = 0; i < 3; i++) begin
            fill_img(2);
            start_run(2, cyc, k);
            finish_run(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
